// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// ExcCode values and writable-bit masks.
package cp0_exc_unit_pkg;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14
    } cp0_reg_e;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_HWIP_LO = 10;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    function automatic logic [31:0] merge_masked(input logic [31:0] cur,
                                                 input logic [31:0] wr,
                                                 input logic [31:0] mask);
        return (cur & ~mask) | (wr & mask);
    endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// Pipeline/arbiter-facing signal bundle of the CP0 exception unit.
interface cp0_exc_unit_if #(parameter int HW_INT_NUM = 6);

    logic                  write_en_i;
    logic [4:0]            write_addr_i;
    logic [31:0]           write_data_i;
    logic [4:0]            read_addr_i;
    logic [31:0]           read_data_o;
    logic [HW_INT_NUM-1:0] int_i;
    logic                  exc_valid_i;
    logic [4:0]            exc_code_i;
    logic [31:0]           exc_pc_i;
    logic                  exc_bd_i;
    logic [31:0]           exc_badvaddr_i;
    logic                  eret_i;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;
    logic [31:0]           count_o;
    logic [31:0]           compare_o;
    logic [31:0]           badvaddr_o;
    logic                  timer_int_o;
    logic                  int_req_o;

    modport master (
        output write_en_i, write_addr_i, write_data_i, read_addr_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        input  read_data_o, status_o, cause_o, epc_o, count_o, compare_o,
               badvaddr_o, timer_int_o, int_req_o
    );

    modport slave (
        input  write_en_i, write_addr_i, write_data_i, read_addr_i, int_i,
               exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, exc_badvaddr_i, eret_i,
        output read_data_o, status_o, cause_o, epc_o, count_o, compare_o,
               badvaddr_o, timer_int_o, int_req_o
    );

endinterface

// File: rtl/cp0_exc_unit_timer.sv
// CP0 timer: Count with optional divide-by-2 prescaler, Compare, and the
// sticky timer interrupt flag.
module cp0_exc_unit_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic phase;
    logic tick;

    assign tick = (COUNT_DIV == 1) ? 1'b1 : phase;

    // A Count write restarts the prescaler; a Compare write beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            phase     <= 1'b0;
            timer_int <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                phase <= 1'b0;
            end else begin
                if (tick)
                    count <= count + 32'd1;
                phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
            end
            if (compare_we) begin
                compare   <= wdata;
                timer_int <= 1'b0;
            end else if (compare != '0 && count == compare) begin
                timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file with precise exception entry, ERET and interrupt request.
// Define CP0_READ_BYPASS_EN to forward a same-cycle MTC0 write onto the MFC0 read.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000,
    parameter int          TIMER_IP   = 7
) (
    input logic          clk,
    input logic          rst,
    cp0_exc_unit_if.slave bus
);

    logic [31:0] status, cause, epc, badvaddr, count, compare;
    logic [31:0] status_next, cause_next, epc_next;
    logic [31:0] rd_status, rd_cause, rd_epc, rd_count, rd_compare;
    logic        timer_int, int_req;
    logic        count_we, compare_we, status_we, cause_we, epc_we;
    logic        exl, addr_exc;
    logic [5:0]  hw_ip, ip_sample;

    assign count_we   = bus.write_en_i && (bus.write_addr_i == CP0_COUNT);
    assign compare_we = bus.write_en_i && (bus.write_addr_i == CP0_COMPARE);
    assign status_we  = bus.write_en_i && (bus.write_addr_i == CP0_STATUS);
    assign cause_we   = bus.write_en_i && (bus.write_addr_i == CP0_CAUSE);
    assign epc_we     = bus.write_en_i && (bus.write_addr_i == CP0_EPC);
    assign exl        = status[STATUS_EXL];
    assign addr_exc   = (bus.exc_code_i == EXC_ADEL) || (bus.exc_code_i == EXC_ADES);

    cp0_exc_unit_timer #(.COUNT_DIV(COUNT_DIV)) u_cp0_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (bus.write_data_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int)
    );

    always_comb begin
        hw_ip     = 6'(bus.int_i);
        ip_sample = hw_ip;
        ip_sample[TIMER_IP-2] = hw_ip[TIMER_IP-2] | timer_int;
    end

    // Later assignments win: exception over ERET over MTC0 on shared fields.
    always_comb begin
        status_next = status_we ? merge_masked(status, bus.write_data_i, STATUS_WMASK) : status;
        cause_next  = cause_we ? merge_masked(cause, bus.write_data_i, CAUSE_WMASK) : cause;
        epc_next    = epc_we ? bus.write_data_i : epc;
        cause_next[CAUSE_HWIP_LO +: 6] = ip_sample;
        if (bus.eret_i)
            status_next[STATUS_EXL] = 1'b0;
        if (bus.exc_valid_i) begin
            status_next[STATUS_EXL] = 1'b1;
            cause_next[CAUSE_EXC_HI:CAUSE_EXC_LO] = bus.exc_code_i;
            if (!exl) begin
                epc_next = bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
                cause_next[CAUSE_BD] = bus.exc_bd_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status   <= STATUS_RST;
            cause    <= '0;
            epc      <= '0;
            badvaddr <= '0;
            int_req  <= 1'b0;
        end else begin
            status <= status_next;
            cause  <= cause_next;
            epc    <= epc_next;
            if (bus.exc_valid_i && addr_exc)
                badvaddr <= bus.exc_badvaddr_i;
            int_req <= status[STATUS_IE] & ~status[STATUS_EXL] &
                       (|(cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]));
        end
    end

    always_comb begin
        rd_status  = status;
        rd_cause   = cause;
        rd_epc     = epc;
        rd_count   = count;
        rd_compare = compare;
`ifdef CP0_READ_BYPASS_EN
        if (status_we)  rd_status  = merge_masked(status, bus.write_data_i, STATUS_WMASK);
        if (cause_we)   rd_cause   = merge_masked(cause, bus.write_data_i, CAUSE_WMASK);
        if (epc_we)     rd_epc     = bus.write_data_i;
        if (count_we)   rd_count   = bus.write_data_i;
        if (compare_we) rd_compare = bus.write_data_i;
`endif
        bus.read_data_o = '0;
        if (!rst) begin
            case (bus.read_addr_i)
                CP0_BADVADDR: bus.read_data_o = badvaddr;
                CP0_COUNT:    bus.read_data_o = rd_count;
                CP0_COMPARE:  bus.read_data_o = rd_compare;
                CP0_STATUS:   bus.read_data_o = rd_status;
                CP0_CAUSE:    bus.read_data_o = rd_cause;
                CP0_EPC:      bus.read_data_o = rd_epc;
                default:      bus.read_data_o = '0;
            endcase
        end
    end

    assign bus.status_o    = status;
    assign bus.cause_o     = cause;
    assign bus.epc_o       = epc;
    assign bus.count_o     = count;
    assign bus.compare_o   = compare;
    assign bus.badvaddr_o  = badvaddr;
    assign bus.timer_int_o = timer_int;
    assign bus.int_req_o   = int_req;

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Parametrised CP0 block: Count, Compare, Status, Cause, EPC and BadVAddr registers, plus precise exception entry, ERET return and a level interrupt request.
- Sits beside the MEM/WB boundary. MTC0/MFC0 traffic comes from the pipeline; exception and ERET events come from the exception arbiter.
- Produces `int_req_o` for the arbiter and the EPC target for the PC mux.

Parameters:
- HW_INT_NUM, 6: number of external interrupt lines, range 1..6. They map to Cause.IP[2+HW_INT_NUM-1:2], i.e. Cause bits 10 upward. Unused IP bits read 0.
- COUNT_DIV, 1: Count increments once every COUNT_DIV cycles. Legal values are 1 and 2.
- STATUS_RST, 32'h1000_0000: Status reset value (CU0=1).
- TIMER_IP, 7: IP bit that the timer interrupt is ORed into.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- write_en_i  in  1  MTC0 write strobe.
- write_addr_i  in  5  MTC0 register number.
- write_data_i  in  32  MTC0 data.
- read_addr_i  in  5  MFC0 register number.
- read_data_o  out  32  MFC0 data (combinational).
- int_i  in  HW_INT_NUM  external interrupt levels.
- exc_valid_i  in  1  exception commit, one cycle.
- exc_code_i  in  5  ExcCode.
- exc_pc_i  in  32  PC of the faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- exc_badvaddr_i  in  32  faulting address.
- eret_i  in  1  ERET commit, one cycle.
- status_o  out  32  Status register.
- cause_o  out  32  Cause register.
- epc_o  out  32  EPC register.
- count_o  out  32  Count register.
- compare_o  out  32  Compare register.
- badvaddr_o  out  32  BadVAddr register.
- timer_int_o  out  1  timer interrupt pending.
- int_req_o  out  1  interrupt request to the arbiter.

Behaviour:
- **Clock and reset.** Single clock `clk`; reset `rst` is synchronous and active-high.
- **Reset values.** Status = STATUS_RST; all other registers = 0. timer_int_o = 0; int_req_o = 0; read_data_o = 0 while rst is high. The COUNT_DIV phase bit also resets to 0.
- **Register map.**
  - 8 BadVAddr (read-only)
  - 9 Count
  - 11 Compare
  - 12 Status (writable bits [15:8] and [1:0] only)
  - 13 Cause (writable bits [9:8] only)
  - 14 EPC
  - Writes to any other address are ignored; reads of any other address return 0.
- **MTC0 latency.** Writes take effect at the next clk edge.
- **Count.** Increments every COUNT_DIV cycles and wraps from FFFF_FFFF to 0.
  - A Count write overrides the increment in the same cycle.
  - A Count write resets the divider phase.
- **Timer.**
  - When Compare != 0 and Count == Compare, timer_int_o is set to 1 at the next edge and held.
  - A Compare write clears timer_int_o. This clear wins over a same-cycle match.
- **Cause.IP sampling.**
  - Cause.IP[7:2] is resampled every cycle: external lines go to bits 2.., and timer_int_o is ORed into TIMER_IP.
  - MTC0 never writes bits [15:10].
- **Exception entry** (exc_valid_i=1):
  - Status.EXL (bit 1) <= 1.
  - Cause.ExcCode [6:2] <= exc_code_i.
  - If EXL was 0 before the event:
    - EPC <= exc_bd_i ? exc_pc_i-4 : exc_pc_i.
    - Cause.BD (bit 31) <= exc_bd_i.
  - If EXL was already 1, EPC and BD are held.
  - BadVAddr <= exc_badvaddr_i only when exc_code_i is 4 (AdEL) or 5 (AdES).
- **ERET** (eret_i=1): Status.EXL <= 0.
- **Priority on the same cycle:** exception > ERET > MTC0 to the same field. An MTC0 write to fields the exception does not touch still completes.
- **int_req_o** is registered: Status.IE (bit 0) & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[15:8]), taken from the current register values. Latency is one cycle after the IP bit sets.
- **Reset mid-operation.** rst overrides every concurrent event.

Optional Feature:
- Macro: CP0_READ_BYPASS_EN.
- **Defined:** when write_en_i=1 and write_addr_i == read_addr_i in the same cycle, read_data_o returns the post-write value. Writable-bit masking is applied, so a Status/Cause bypass merges write_data_i into the current register value.
- **Undefined:** read_data_o always returns the registered value, and the write becomes visible the next cycle.

Decomposition:
- Shared header with the existing CP0 defines:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - Status/Cause field bit positions (IE, EXL, IM, IP, BD, ExcCode).
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- One natural sub-module, cp0_timer: Count, divider, Compare and timer_int_o, with Count/Compare write strobes as inputs.

Test Plan:
- **Reset:** pulse rst, write Status=FFFF_FFFF in the same cycle → Status=1000_0000, Count=0, timer_int_o=0.
- **Timer:**
  - Write Compare=5, Count=0, COUNT_DIV=1 → timer_int_o=1 after the cycle where Count==5; Cause[15]=1.
  - Write Compare=9 → timer_int_o=0 next cycle.
- **Interrupt request:** Status=0000_FF01, int_i[0]=1 → Cause[10]=1, then int_req_o=1 one cycle later. Set EXL → int_req_o=0.
- **Nested exception:**
  - exc_valid_i with code 4, pc=0x80, bd=1, badvaddr=0x1233 → EPC=0x7C, BD=1, ExcCode=4, BadVAddr=0x1233, EXL=1.
  - Second exception with code 12, pc=0x200 → EPC=0x7C held, ExcCode=12, BadVAddr unchanged.
- **Collisions:**
  - Same cycle: exc_valid_i + eret_i + MTC0 Status=0 → EXL=1, IM cleared.
  - Count write 0x10 on a COUNT_DIV=2 increment cycle → Count=0x10.
  - Count=FFFF_FFFF → 0 wrap.
- **Bypass:** MTC0 EPC=0xABCD with read_addr=14 in the same cycle → 0xABCD with CP0_READ_BYPASS_EN, old EPC without it.
